// File: rtl/instr_fetch.sv
// Instruction fetch unit: samples the PC, reads a 16-bit word over req/ack, holds cond/operand for the consumer.
// Define FETCH_TIMEOUT_EN to compile in the ack watchdog, the ERR state and Fetch_Err.
module instr_fetch #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic [7:0]  Addres_Instruction_Bus,
  output logic        Mem_Req,
  output logic [7:0]  Mem_Addr,
  input  logic        Mem_Ack,
  input  logic [15:0] Mem_Data,
  input  logic        Stall,
  output logic [5:0]  cond,
  output logic [7:0]  DataOut_Bus,
  output logic        Instr_Valid,
  output logic        Fetch_Err
);

  // state | meaning
  // IDLE  | sample PC into Mem_Addr, start a new fetch
  // REQ   | Mem_Req high, waiting for Mem_Ack
  // HOLD  | instruction valid, waiting for Stall=0
  // ERR   | memory never answered, parked until reset (FETCH_TIMEOUT_EN only)
`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_ERR} state_t;
  localparam logic [7:0] TIMEOUT_CNT = TIMEOUT[7:0];
`else
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD} state_t;
  localparam int unsigned UNUSED_TIMEOUT = TIMEOUT;
`endif

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [5:0]  cond_q, cond_d;
  logic [7:0]  dout_q, dout_d;
  logic        req_q;
  logic        valid_q;
  logic        unused_rsvd;

  // Instruction bits [9:8] are reserved.
  assign unused_rsvd = ^Mem_Data[9:8];

`ifdef FETCH_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cond_d  = cond_q;
    dout_d  = dout_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        addr_d  = Addres_Instruction_Bus;
        state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      S_REQ: begin
        if (Mem_Ack) begin
          // A PC change while the read was in flight makes the reply stale.
          if (Addres_Instruction_Bus == addr_q) begin
            cond_d  = Mem_Data[15:10];
            dout_d  = Mem_Data[7:0];
            state_d = S_HOLD;
          end else begin
            state_d = S_IDLE;
          end
        end
`ifdef FETCH_TIMEOUT_EN
        else begin
          cnt_d = cnt_q + 8'd1;
          if (cnt_d == TIMEOUT_CNT) state_d = S_ERR;
        end
`endif
      end
      S_HOLD: begin
        if (!Stall) state_d = S_IDLE;
      end
`ifdef FETCH_TIMEOUT_EN
      S_ERR: begin
        state_d = S_ERR;
      end
`endif
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q <= S_IDLE;
      addr_q  <= 8'h00;
      cond_q  <= 6'd0;
      dout_q  <= 8'h00;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cond_q  <= cond_d;
      dout_q  <= dout_d;
      req_q   <= (state_d == S_REQ);
      valid_q <= (state_d == S_HOLD);
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= (state_d == S_ERR);
    end
  end

  assign Fetch_Err = err_q;
`else
  assign Fetch_Err = 1'b0;
`endif

  assign Mem_Req     = req_q;
  assign Mem_Addr    = addr_q;
  assign cond        = cond_q;
  assign DataOut_Bus = dout_q;
  assign Instr_Valid = valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: table vectors, hand-written corner sequences, randomized fetches.
// Works with or without FETCH_TIMEOUT_EN defined.
module tb_instr_fetch;

  logic        Clk;
  logic        Rst;
  logic [7:0]  Addres_Instruction_Bus;
  logic        Mem_Req;
  logic [7:0]  Mem_Addr;
  logic        Mem_Ack;
  logic [15:0] Mem_Data;
  logic        Stall;
  logic [5:0]  cond;
  logic [7:0]  DataOut_Bus;
  logic        Instr_Valid;
  logic        Fetch_Err;

  int checks   = 0;
  int failures = 0;

  logic [5:0] last_cond;
  logic [7:0] last_dout;

`ifdef FETCH_TIMEOUT_EN
  localparam int MAXW = 3;
`else
  localparam int MAXW = 6;
`endif

  instr_fetch #(.TIMEOUT(4)) dut (
    .Clk                    (Clk),
    .Rst                    (Rst),
    .Addres_Instruction_Bus (Addres_Instruction_Bus),
    .Mem_Req                (Mem_Req),
    .Mem_Addr               (Mem_Addr),
    .Mem_Ack                (Mem_Ack),
    .Mem_Data               (Mem_Data),
    .Stall                  (Stall),
    .cond                   (cond),
    .DataOut_Bus            (DataOut_Bus),
    .Instr_Valid            (Instr_Valid),
    .Fetch_Err              (Fetch_Err)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit expired");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"},   Mem_Req, 0);
    chk({tag, "_addr"},  Mem_Addr, 8'h00);
    chk({tag, "_cond"},  cond, 6'd0);
    chk({tag, "_dout"},  DataOut_Bus, 8'h00);
    chk({tag, "_valid"}, Instr_Valid, 0);
    chk({tag, "_err"},   Fetch_Err, 0);
  endtask

  // One fetch starting with the DUT in IDLE. If redir_at is within 0..w the PC moves to p2
  // at that REQ cycle, so the ack is stale and the task ends after the single IDLE cycle.
  task automatic fetch(input logic [7:0] p, input logic [15:0] word, input int w, input int s,
                       input int redir_at, input logic [7:0] p2,
                       input logic [5:0] ec, input logic [7:0] ed);
    Addres_Instruction_Bus = p;
    Mem_Ack = 1'b0;
    Stall   = 1'b0;
    @(negedge Clk);
    for (int i = 0; i <= w; i++) begin
      chk("req_high", Mem_Req, 1);
      chk("req_addr", Mem_Addr, p);
      chk("req_valid_low", Instr_Valid, 0);
      if (i == redir_at) Addres_Instruction_Bus = p2;
      Mem_Ack  = (i == w);
      Mem_Data = (i == w) ? word : 16'($urandom);
      @(negedge Clk);
    end
    Mem_Ack = 1'b0;
    if (redir_at >= 0 && redir_at <= w) begin
      chk("redir_req_low", Mem_Req, 0);
      chk("redir_valid_low", Instr_Valid, 0);
      chk("redir_cond_kept", cond, last_cond);
      chk("redir_dout_kept", DataOut_Bus, last_dout);
      return;
    end
    for (int j = 0; j <= s; j++) begin
      chk("hold_valid", Instr_Valid, 1);
      chk("hold_req_low", Mem_Req, 0);
      chk("hold_cond", cond, ec);
      chk("hold_dout", DataOut_Bus, ed);
      Stall = (j < s);
      if (j < s) begin
        Addres_Instruction_Bus = 8'($urandom);
        Mem_Ack = 1'($urandom);
      end else begin
        Addres_Instruction_Bus = p;
        Mem_Ack = 1'b0;
      end
      @(negedge Clk);
    end
    Stall = 1'b0;
    chk("idle_valid_low", Instr_Valid, 0);
    chk("idle_req_low", Mem_Req, 0);
    last_cond = ec;
    last_dout = ed;
  endtask

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
    int          w;
    int          s;
    logic [5:0]  ec;
    logic [7:0]  ed;
  } vec_t;

  vec_t tbl[5];

  initial begin
    logic [7:0]  p, p2;
    logic [15:0] word;
    int          w, s, r, n;

    tbl[0] = '{pc: 8'h03, word: 16'hA803, w: 0, s: 0, ec: 6'b101010, ed: 8'h03};
    tbl[1] = '{pc: 8'h0B, word: 16'h2C0B, w: 0, s: 4, ec: 6'b001011, ed: 8'h0B};
    tbl[2] = '{pc: 8'h31, word: 16'h9431, w: 3, s: 0, ec: 6'b100101, ed: 8'h31};
    tbl[3] = '{pc: 8'hC7, word: 16'h03C7, w: 1, s: 1, ec: 6'b000000, ed: 8'hC7};
    tbl[4] = '{pc: 8'hFF, word: 16'hFC00, w: 2, s: 2, ec: 6'b111111, ed: 8'h00};

    Rst = 1'b1;
    Addres_Instruction_Bus = 8'h00;
    Mem_Ack  = 1'b1;
    Mem_Data = 16'hFFFF;
    Stall    = 1'b0;
    last_cond = 6'd0;
    last_dout = 8'h00;
    repeat (3) @(negedge Clk);
    chk_reset_vals("reset");
    Mem_Ack = 1'b0;
    Rst = 1'b0;

    for (int k = 0; k < 5; k++)
      fetch(tbl[k].pc, tbl[k].word, tbl[k].w, tbl[k].s, -1, 8'h00, tbl[k].ec, tbl[k].ed);

    fetch(8'h10, 16'hDEAD, 2, 0, 1, 8'h23, 6'd0, 8'h00);
    fetch(8'h23, 16'h7C23, 0, 0, -1, 8'h00, 6'b011111, 8'h23);

    for (int k = 0; k < 30; k++) begin
      p    = 8'($urandom);
      word = 16'($urandom);
      w    = int'($urandom_range(0, MAXW));
      s    = int'($urandom_range(0, 3));
      r    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, w)) : -1;
      if (r >= 0) begin
        p2 = p ^ 8'($urandom_range(1, 255));
        fetch(p, 16'($urandom), w, 0, r, p2, 6'd0, 8'h00);
        p = p2;
      end
      fetch(p, word, w, s, -1, 8'h00, word[15:10], word[7:0]);
    end

    Addres_Instruction_Bus = 8'h44;
    Mem_Ack = 1'b0;
    @(negedge Clk);
    chk("rst_mid_req_before", Mem_Req, 1);
    #2 Rst = 1'b1;
    #1;
    chk_reset_vals("rst_async");
    Mem_Ack  = 1'b1;
    Mem_Data = 16'h1144;
    @(negedge Clk);
    chk_reset_vals("rst_ack_ignored");
    Rst = 1'b0;
    Mem_Ack = 1'b0;
    Addres_Instruction_Bus = 8'h46;
    @(negedge Clk);
    chk("rst_release_req", Mem_Req, 1);
    chk("rst_release_addr", Mem_Addr, 8'h46);
    Mem_Ack  = 1'b1;
    Mem_Data = 16'h5046;
    @(negedge Clk);
    Mem_Ack = 1'b0;
    chk("rst_release_valid", Instr_Valid, 1);
    chk("rst_release_cond", cond, 6'b010100);
    chk("rst_release_dout", DataOut_Bus, 8'h46);
    @(negedge Clk);
    chk("rst_release_idle", Instr_Valid, 0);

    Addres_Instruction_Bus = 8'h55;
    Mem_Ack = 1'b0;
    @(negedge Clk);
    n = 0;
`ifdef FETCH_TIMEOUT_EN
    while (Mem_Req === 1'b1 && n < 60) begin
      n++;
      @(negedge Clk);
    end
    chk("timeout_req_cycles", n, 4);
    chk("timeout_err", Fetch_Err, 1);
    chk("timeout_valid_low", Instr_Valid, 0);
    Mem_Ack  = 1'b1;
    Mem_Data = 16'h0455;
    repeat (3) @(negedge Clk);
    Mem_Ack = 1'b0;
    chk("timeout_late_ack_req", Mem_Req, 0);
    chk("timeout_late_ack_valid", Instr_Valid, 0);
    chk("timeout_late_ack_err", Fetch_Err, 1);
    Rst = 1'b1;
    #1;
    chk("timeout_rst_err", Fetch_Err, 0);
    @(negedge Clk);
    Rst = 1'b0;
`else
    while (Mem_Req === 1'b1 && n < 50) begin
      n++;
      @(negedge Clk);
    end
    chk("no_timeout_req_cycles", n, 50);
    chk("no_timeout_req_still", Mem_Req, 1);
    chk("no_timeout_err", Fetch_Err, 0);
    Mem_Ack  = 1'b1;
    Mem_Data = 16'h0455;
    @(negedge Clk);
    Mem_Ack = 1'b0;
    chk("no_timeout_late_valid", Instr_Valid, 1);
    chk("no_timeout_late_dout", DataOut_Bus, 8'h55);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the 8-bit microprocessor. Sits between the jump unit and instruction memory: takes the program counter on `Addres_Instruction_Bus`, fetches the 16-bit word over a req/ack memory handshake, and presents the decoded condition field and 8-bit operand to the jump unit and datapath (`cond`, `DataOut_Bus`). Holds each instruction until the consumer accepts it and discards fetches made stale by a PC change.

## Interface
- `TIMEOUT`, default 15: maximum cycles `Mem_Req` waits for `Mem_Ack`; legal range 1..255.
- `Clk`  in  1  system clock, rising edge.
- `Rst`  in  1  reset, asynchronous, active-high.
- `Addres_Instruction_Bus`  in  8  PC from the jump unit.
- `Mem_Req`  out  1  memory read request.
- `Mem_Addr`  out  8  read address; stable while `Mem_Req`=1.
- `Mem_Ack`  in  1  memory reply strobe; `Mem_Data` valid in the same cycle.
- `Mem_Data`  in  16  instruction word.
- `Stall`  in  1  consumer not ready.
- `cond`  out  6  instruction bits [15:10].
- `DataOut_Bus`  out  8  instruction bits [7:0]. Bits [9:8] are reserved and dropped.
- `Instr_Valid`  out  1  `cond`/`DataOut_Bus` hold a valid instruction.
- `Fetch_Err`  out  1  sticky memory timeout flag.

## Operation
- States: IDLE, REQ, HOLD, ERR. Reset state is IDLE.
- IDLE: on the next edge, capture `Addres_Instruction_Bus` into `Mem_Addr`, clear the timeout counter, and go to REQ.
- REQ: `Mem_Req`=1. `Mem_Ack` is sampled on each edge:
  - Ack with `Addres_Instruction_Bus` == `Mem_Addr`: load the instruction register from `Mem_Data` and go to HOLD.
  - Ack with the bus ≠ `Mem_Addr` (redirect): drop the data, leave the instruction register unchanged, and go to IDLE. This re-fetches from the new PC.
  - No ack: increment the 8-bit counter. When the counter reaches `TIMEOUT`, go to ERR.
- HOLD: `Instr_Valid`=1 and `Mem_Req`=0. The outputs stay frozen even if the bus changes. If `Stall`=0 at an edge, the instruction is consumed and the unit goes to IDLE. If `Stall`=1, it stays in HOLD.
- ERR: `Mem_Req`=0, `Instr_Valid`=0, `Fetch_Err`=1. The unit stays in ERR until `Rst`.
- `Mem_Ack` is ignored whenever `Mem_Req`=0, including a late ack after reset or after a timeout.
- `cond` and `DataOut_Bus` are always driven from the instruction register. Their values are meaningful only while `Instr_Valid`=1.

## Timing
- Reset values: `Mem_Req`=0, `Mem_Addr`=0x00, `cond`=0, `DataOut_Bus`=0x00, `Instr_Valid`=0, `Fetch_Err`=0, counter=0.
- Asserting `Rst` drops `Mem_Req` immediately, with no clock edge needed.
- All outputs are registered; there is no combinational path from an input to an output.
- Best-case latency (ack in the first REQ cycle):
  - Edge t0 in IDLE: PC sampled.
  - `Mem_Req` is high during cycle t0..t1.
  - Ack sampled at t1.
  - `Instr_Valid`=1 from t1 onward.
- Throughput with `Stall`=0 and zero-wait memory is one instruction per 3 cycles: IDLE, REQ, HOLD.
- Each additional memory wait cycle adds exactly one cycle to the latency.
- The timeout fires on the edge where the count of consecutive ack-less REQ cycles equals `TIMEOUT`. An ack arriving on that same edge wins over the timeout.
- A redirect costs one IDLE cycle plus a new fetch.

## Configuration
- `FETCH_TIMEOUT_EN` defined: the watchdog counter, the REQ→ERR transition, the ERR state, and `Fetch_Err` are all compiled in, as described above.
- `FETCH_TIMEOUT_EN` undefined: there is no counter and no ERR state. REQ waits indefinitely for `Mem_Ack`. `Fetch_Err` is tied to 0. The `TIMEOUT` parameter is accepted but unused.

## Test plan
- Basic fetch: reset, PC=0x03, memory acks on the first REQ cycle with 0xA803, `Stall`=0.
  - Expect `Mem_Addr`=0x03 and `Mem_Req` for 1 cycle.
  - Then `Instr_Valid`=1 for 1 cycle with `cond`=6'b101010 and `DataOut_Bus`=0x03.
- Stall hold: PC=0x0B, data 0x2C0B, `Stall`=1 for 4 cycles.
  - Expect `Instr_Valid`, `cond`=6'b001011 and `DataOut_Bus`=0x0B constant for 5 cycles, with no new `Mem_Req`.
  - The unit goes to IDLE on the first edge with `Stall`=0.
- Redirect: PC=0x10 requested, PC changes to 0x23 before an ack arriving 2 cycles later.
  - Expect the first data discarded, `Instr_Valid` staying 0, one IDLE cycle, then `Mem_Addr`=0x23 and the correct instruction delivered.
- Wait states: ack delayed 3 cycles.
  - Expect `Mem_Req` high for exactly 4 cycles with `Mem_Addr` stable, and `Instr_Valid` rising on the cycle after the ack.
- Timeout (`FETCH_TIMEOUT_EN`, `TIMEOUT`=4): no ack.
  - Expect `Mem_Req` to fall and `Fetch_Err`=1 after 4 REQ cycles.
  - A later `Mem_Ack` is ignored.
  - `Rst` clears `Fetch_Err`.
  - With the macro undefined, `Mem_Req` stays high for 50 cycles and `Fetch_Err`=0.
- Reset mid-fetch: assert `Rst` between edges while in REQ.
  - Expect `Mem_Req`=0 immediately and all outputs at their reset values.
  - An ack during reset is ignored.
  - After release, the fetch starts from the current PC.
